led_sequencer: RTL



---
 rtl/led_seq_pkg.sv | 18 +
 rtl/led_sequencer_tick_prescaler.sv | 29 ++
 rtl/led_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and default widths for the LED pattern sequencer.
package led_seq_pkg;

    localparam int LED_W = 3;
    localparam int DUR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    typedef struct packed {
        logic [LED_W-1:0] pattern;
        logic [DUR_W-1:0] duration;
    } seq_entry_t;

endpackage

// File: rtl/led_sequencer_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/led_sequencer.sv
// Plays a host-loaded table of (pattern, duration) steps onto the LED GPIO bank,
// once or looped, with start/stop control.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV   = 1_200_000,
    parameter int DEPTH      = 16,
    parameter int DUR_W      = led_seq_pkg::DUR_W,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic [LED_W-1:0]           cfg_pattern,
    input  logic [DUR_W-1:0]           cfg_duration,
    input  logic [$clog2(DEPTH):0]     seq_len,
    input  logic                       loop_en,
    input  logic                       start,
    input  logic                       stop,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic [LED_W-1:0]           gpio
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    seq_entry_t         table_q [DEPTH];

    state_t             state_q;
    logic [LED_W-1:0]   led_q;
    logic [DUR_W-1:0]   dur_q;
    logic [DUR_W-1:0]   tcnt_q;
    logic [AW-1:0]      idx_q;
    logic [LW-1:0]      len_q;
    logic               lp_q;
    logic               done_q;
    logic               ready_q;

    logic               tick;
    logic [DUR_W-1:0]   dur_last;
    logic               step_end;
    logic               last_step;
    logic [LW-1:0]      len_d;

    // NOTE: the table has no reset; its contents are undefined until the host loads it.
    always_ff @(posedge clk) begin
        if (cfg_valid && ready_q) begin
            table_q[cfg_addr] <= '{pattern: cfg_pattern, duration: cfg_duration};
        end
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .resetn (resetn),
        .clr    (state_q == LOAD),
        .en     (state_q == RUN),
        .tick   (tick)
    );

    // A zero duration behaves as one tick, so the final tick index is max(dur,1)-1.
    always_comb begin
        dur_last  = (dur_q == '0) ? '0 : dur_q - DUR_W'(1);
        step_end  = (state_q == RUN) && tick && (tcnt_q == dur_last);
        last_step = (({1'b0, idx_q} + LW'(1)) == len_q);
        len_d     = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
    end

    // NOTE: all sequential state uses non-blocking assignments; later assignments in
    // the block (the stop override) take priority over the state-case updates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            led_q   <= '0;
            dur_q   <= '0;
            tcnt_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            lp_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    led_q   <= '0;
                    idx_q   <= '0;
                    ready_q <= 1'b1;
                    if (start && !stop && (seq_len != '0)) begin
                        len_q   <= len_d;
                        lp_q    <= loop_en;
                        state_q <= LOAD;
                        ready_q <= 1'b0;
                    end
                end
                LOAD: begin
                    led_q   <= table_q[idx_q].pattern;
                    dur_q   <= table_q[idx_q].duration;
                    tcnt_q  <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    if (tick) begin
                        tcnt_q <= tcnt_q + DUR_W'(1);
                    end
                    if (step_end) begin
                        if (!last_step) begin
                            idx_q   <= idx_q + AW'(1);
                            state_q <= LOAD;
                        end else if (lp_q) begin
                            idx_q   <= '0;
                            state_q <= LOAD;
                        end else begin
                            idx_q   <= '0;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (stop && (state_q != IDLE)) begin
                state_q <= IDLE;
                led_q   <= '0;
                idx_q   <= '0;
                done_q  <= 1'b0;
                ready_q <= 1'b1;
            end
        end
    end

    assign cfg_ready = ready_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign step_idx  = idx_q;
    assign gpio      = (ACTIVE_LOW != 0) ? ~led_q : led_q;

endmodule
